uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_param_baud_tick.sv | 32 +++
 rtl/uart_tx_param.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
// Parity modes, FSM state encoding and a width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Baud-rate tick generator for the UART transmitter.
// Pulses tick once every CLKS_PER_BIT clocks after clear drops.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign tick   = at_end & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter on the system clock.
// Valid/ready intake, configurable data width, parity and stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 o_bit
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD &&
      PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_FREQ/BAUD must be >= 2");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 par_bit;
  logic                 tick;

  // Counter is held clear while idle so each frame starts phase-aligned
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(ready),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      o_bit   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_en) begin
            shreg   <= data_in;
            par_bit <= (PARITY == PAR_ODD) ? ~^data_in
                                           : ^data_in;
            bit_cnt <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            o_bit   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            o_bit   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                o_bit <= par_bit;
                state <= PAR;
              end else begin
                o_bit <= 1'b1;
                state <= STOP;
              end
            end else begin
              o_bit   <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            o_bit   <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          o_bit <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
